// File: rtl/gpu_pkg.sv
// Shared opcode, flag and write-back entry definitions for the GPU ALU write-back slice.
// Entry rd is stored at RD_MAX_W bits so one entry type serves any RADDR_W up to 8.
package gpu_pkg;

   localparam int OPC_W    = 6;
   localparam int RD_MAX_W = 8;

   localparam logic [OPC_W-1:0] OPC_ADD  = 6'd0;
   localparam logic [OPC_W-1:0] OPC_SUB  = 6'd1;
   localparam logic [OPC_W-1:0] OPC_AND  = 6'd2;
   localparam logic [OPC_W-1:0] OPC_OR   = 6'd3;
   localparam logic [OPC_W-1:0] OPC_XOR  = 6'd4;
   localparam logic [OPC_W-1:0] OPC_SHL  = 6'd5;
   localparam logic [OPC_W-1:0] OPC_SHR  = 6'd6;
   localparam logic [OPC_W-1:0] OPC_SRA  = 6'd7;
   localparam logic [OPC_W-1:0] OPC_MUL  = 6'd8;
   localparam logic [OPC_W-1:0] OPC_MULH = 6'd9;
   localparam logic [OPC_W-1:0] OPC_MIN  = 6'd10;
   localparam logic [OPC_W-1:0] OPC_MAX  = 6'd11;
   localparam logic [OPC_W-1:0] OPC_ROL  = 6'd12;
   localparam logic [OPC_W-1:0] OPC_ROR  = 6'd13;

   localparam int FLAG_Z = 3;
   localparam int FLAG_S = 2;
   localparam int FLAG_O = 1;
   localparam int FLAG_C = 0;

   typedef struct packed {
      logic [OPC_W-1:0]    opc;
      logic [RD_MAX_W-1:0] rd;
      logic [31:0]         result;
      logic [3:0]          flags;
   } wb_entry_t;

   // Only arithmetic ops produce meaningful overflow and carry.
   function automatic logic updates_oc(input logic [OPC_W-1:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_SUB);
   endfunction

endpackage

// File: rtl/gpu_alu_wb_if.sv
// ALU-result input handshake and register-file write port of the write-back stage.
interface gpu_alu_wb_if #(parameter int RADDR_W = 5);

   logic               in_valid;
   logic               in_ready;
   logic [5:0]         in_opc;
   logic [RADDR_W-1:0] in_rd;
   logic [31:0]        in_result;
   logic [3:0]         in_flags;
   logic               rf_we;
   logic               rf_ready;
   logic [RADDR_W-1:0] rf_waddr;
   logic [31:0]        rf_wdata;

   modport master (
      output in_valid, in_opc, in_rd, in_result, in_flags, rf_ready,
      input  in_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  in_valid, in_opc, in_rd, in_result, in_flags, rf_ready,
      output in_ready, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/gpu_wb_fifo.sv
// Result queue for the write-back stage: DEPTH entries of a generic entry type, FIFO order.
module gpu_wb_fifo
   import gpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  entry_t           wr_entry,
   output entry_t           head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/gpu_alu_wb.sv
// ALU write-back stage: queues results, writes them to the register file in order, pulses
// scoreboard clears and tracks architectural flags (flag storage only with GPU_WB_FLAGS_EN).
module gpu_alu_wb
   import gpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter int  RADDR_W = 5,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   gpu_alu_wb_if.slave        bus,
   input  logic               flush,
   output logic               sb_clr,
   output logic [RADDR_W-1:0] sb_idx,
   output logic [3:0]         flags_q,
   output logic [CNT_W-1:0]   count
);

   wb_entry_t wr_entry;
   wb_entry_t head;
   logic      full;
   logic      empty;
   logic      push;
   logic      pop;
   logic      head_r0;
   logic      unused_head_bits;

   always_comb begin
      wr_entry        = '0;
      wr_entry.opc    = bus.in_opc;
      wr_entry.rd     = RD_MAX_W'(bus.in_rd);
      wr_entry.result = bus.in_result;
`ifdef GPU_WB_FLAGS_EN
      wr_entry.flags  = bus.in_flags;
`endif
   end

   gpu_wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (wb_entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   // r0 results retire without touching the register file; flush blocks any retirement.
   assign head_r0      = (head.rd == '0);
   assign bus.in_ready = !full && !flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign bus.rf_we    = !empty && !head_r0 && !flush;
   assign pop          = !flush && !empty && (head_r0 || bus.rf_ready);
   assign bus.rf_waddr = head.rd[RADDR_W-1:0];
   assign bus.rf_wdata = head.result;

   assign unused_head_bits = ^{head.opc, head.flags, head.rd};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_clr <= 1'b0;
         sb_idx <= '0;
      end else begin
         sb_clr <= pop;
         if (pop) sb_idx <= head.rd[RADDR_W-1:0];
      end
   end

`ifdef GPU_WB_FLAGS_EN
   logic [3:0] flags_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= '0;
      end else if (pop) begin
         flags_r[FLAG_Z] <= head.flags[FLAG_Z];
         flags_r[FLAG_S] <= head.flags[FLAG_S];
         if (updates_oc(head.opc)) begin
            flags_r[FLAG_O] <= head.flags[FLAG_O];
            flags_r[FLAG_C] <= head.flags[FLAG_C];
         end
      end
   end

   assign flags_q = flags_r;
`else
   assign flags_q = '0;
`endif

endmodule

// File: tb/tb_gpu_alu_wb.sv
// Scoreboard bench for gpu_alu_wb: a reference queue predicts every write, retire and flag value.
module tb_gpu_alu_wb;
   import gpu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int RADDR_W = 5;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               flush = 1'b0;
   logic               sb_clr;
   logic [RADDR_W-1:0] sb_idx;
   logic [3:0]         flags_q;
   logic [CNT_W-1:0]   count;

   gpu_alu_wb_if #(.RADDR_W(RADDR_W)) bus ();

   gpu_alu_wb #(
      .DEPTH   (DEPTH),
      .RADDR_W (RADDR_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .flush   (flush),
      .sb_clr  (sb_clr),
      .sb_idx  (sb_idx),
      .flags_q (flags_q),
      .count   (count)
   );

   always #5 clk = ~clk;

   int                 checkCount = 0;
   int                 failCount  = 0;
   wb_entry_t          expQ[$];
   logic               expSbClr;
   logic [RADDR_W-1:0] expSbIdx;
   logic [3:0]         expFlags;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [5:0] opc, input logic [RADDR_W-1:0] rd,
                                input logic [31:0] res, input logic [3:0] fl, input logic rdy,
                                input logic fsh);
      bus.in_valid  = v;
      bus.in_opc    = opc;
      bus.in_rd     = rd;
      bus.in_result = res;
      bus.in_flags  = fl;
      bus.rf_ready  = rdy;
      flush         = fsh;
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, OPC_ADD, '0, 32'h0, 4'h0, rdy, 1'b0);
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic stepCycle();
      logic      expReady;
      logic      expWe;
      logic      expPop;
      logic      expPush;
      wb_entry_t h;
      wb_entry_t e;
      #1;
      expReady = (expQ.size() < DEPTH) && !flush;
      expWe    = (expQ.size() > 0) && (expQ[0].rd != '0) && !flush;
      checkOutput("in_ready", 64'(bus.in_ready), 64'(expReady));
      checkOutput("rf_we", 64'(bus.rf_we), 64'(expWe));
      if (expWe) begin
         checkOutput("rf_waddr", 64'(bus.rf_waddr), 64'(expQ[0].rd[RADDR_W-1:0]));
         checkOutput("rf_wdata", 64'(bus.rf_wdata), 64'(expQ[0].result));
      end
      checkOutput("count", 64'(count), 64'(expQ.size()));
      checkOutput("sb_clr", 64'(sb_clr), 64'(expSbClr));
      checkOutput("sb_idx", 64'(sb_idx), 64'(expSbIdx));
      checkOutput("flags_q", 64'(flags_q), 64'(expFlags));
      expPop  = !flush && (expQ.size() > 0) && ((expQ[0].rd == '0) || bus.rf_ready);
      expPush = bus.in_valid && expReady;
      e        = '0;
      e.opc    = bus.in_opc;
      e.rd     = RD_MAX_W'(bus.in_rd);
      e.result = bus.in_result;
      e.flags  = bus.in_flags;
      @(posedge clk);
      if (flush) begin
         expQ.delete();
         expSbClr = 1'b0;
      end else begin
         expSbClr = expPop;
         if (expPop) begin
            h        = expQ.pop_front();
            expSbIdx = h.rd[RADDR_W-1:0];
`ifdef GPU_WB_FLAGS_EN
            expFlags[FLAG_Z] = h.flags[FLAG_Z];
            expFlags[FLAG_S] = h.flags[FLAG_S];
            if (h.opc == OPC_ADD || h.opc == OPC_SUB) begin
               expFlags[FLAG_O] = h.flags[FLAG_O];
               expFlags[FLAG_C] = h.flags[FLAG_C];
            end
`endif
         end
         if (expPush) expQ.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle(1'b1);
      expQ.delete();
      expSbClr = 1'b0;
      expSbIdx = '0;
      expFlags = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stepCycle();

      // Single write to r3.
      applyStimulus(1'b1, OPC_ADD, 5'd3, 32'h0000_0005, 4'h0, 1'b1, 1'b0);
      stepCycle();
      idle(1'b1);
      repeat (3) stepCycle();

      // Fill against a stalled register file, then release.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, OPC_XOR, RADDR_W'(i + 1), 32'h100 + 32'(i), 4'h0, 1'b0, 1'b0);
         stepCycle();
      end
      idle(1'b0);
      stepCycle();
      idle(1'b1);
      repeat (6) stepCycle();

      // r0 destination retires silently.
      applyStimulus(1'b1, OPC_OR, 5'd0, 32'hDEAD_BEEF, 4'h0, 1'b1, 1'b0);
      stepCycle();
      idle(1'b1);
      repeat (3) stepCycle();

      // Overflow/carry held across a logical op.
      applyStimulus(1'b1, OPC_ADD, 5'd7, 32'h1, 4'b0011, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b1, OPC_XOR, 5'd8, 32'h2, 4'b1000, 1'b1, 1'b0);
      stepCycle();
      idle(1'b1);
      repeat (3) stepCycle();
`ifdef GPU_WB_FLAGS_EN
      checkOutput("flags_hold", 64'(flags_q), 64'(4'b1011));
`else
      checkOutput("flags_tied", 64'(flags_q), 64'(4'b0000));
`endif

      // Flush with a queued backlog and a valid input.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, OPC_SUB, RADDR_W'(i + 10), 32'hA0 + 32'(i), 4'b1111, 1'b0, 1'b0);
         stepCycle();
      end
      applyStimulus(1'b1, OPC_ADD, 5'd20, 32'hFFFF, 4'b0101, 1'b1, 1'b1);
      stepCycle();
      idle(1'b1);
      repeat (3) stepCycle();

      // Random traffic, including r0, stalls and occasional flushes.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 13)),
                       RADDR_W'($urandom_range(0, 3)), $urandom(), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
         stepCycle();
      end
      idle(1'b1);
      repeat (6) stepCycle();

      // Asynchronous reset with two entries queued.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, OPC_ADD, RADDR_W'(i + 4), 32'h55 + 32'(i), 4'b1111, 1'b0, 1'b0);
         stepCycle();
      end
      idle(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      expQ.delete();
      expSbClr = 1'b0;
      expSbIdx = '0;
      expFlags = '0;
      checkOutput("rst_count", 64'(count), 64'(0));
      checkOutput("rst_rf_we", 64'(bus.rf_we), 64'(0));
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
      checkOutput("rst_sb_clr", 64'(sb_clr), 64'(0));
      checkOutput("rst_sb_idx", 64'(sb_idx), 64'(0));
      checkOutput("rst_flags_q", 64'(flags_q), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      repeat (4) stepCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/gpu_alu_wb.md
GPU_ALU_WB -- requirements
Module: gpu_alu_wb

Interface
REQ-001 Parameter DEPTH, default 4, number of queued ALU results; power of two, at least 2.
REQ-002 Parameter RADDR_W, default 5, register-file address width.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset (clk, rst_n).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  ALU result valid.
REQ-007 in_ready  out  1  stage can accept a result.
REQ-008 in_opc  in  6  opcode that produced the result.
REQ-009 in_rd  in  RADDR_W  destination register.
REQ-010 in_result  in  32  ALU output.
REQ-011 in_flags  in  4  {z,s,o,c} from ALU.
REQ-012 flush  in  1  synchronous discard of all queued results.
REQ-013 rf_we  out  1  register-file write request.
REQ-014 rf_ready  in  1  register file accepts the write this cycle.
REQ-015 rf_waddr  out  RADDR_W  write address.
REQ-016 rf_wdata  out  32  write data.
REQ-017 sb_clr  out  1  one-cycle scoreboard-clear pulse.
REQ-018 sb_idx  out  RADDR_W  register being cleared.
REQ-019 flags_q  out  4  architectural {z,s,o,c}.
REQ-020 count  out  clog2(DEPTH+1)  queued entry count.

Function
REQ-021 Push SHALL occur when in_valid && in_ready; in_ready = !full && !flush, combinational.
REQ-022 Entries SHALL leave in FIFO order; no bypass: a result pushed at edge N is first visible on rf_we after edge N.
REQ-023 rf_we = !empty && head.rd != 0; rf_waddr/rf_wdata show head entry; both stable until popped.
REQ-024 Pop SHALL occur on (rf_we && rf_ready) or (!empty && head.rd == 0); r0 entries retire in one cycle without a write.
REQ-025 sb_clr SHALL be registered, asserting the cycle after every pop for one cycle, sb_idx = popped rd (r0 included).
REQ-026 On pop, flags_q z and s SHALL take the head's flags; o and c update only when head opc is 0 (add) or 1 (sub), else hold.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; allowed at full only if pop occurs, but in_ready stays 0 when full (no push at full).
REQ-028 Pointers SHALL wrap modulo DEPTH; count saturates logically at DEPTH (no overflow possible by REQ-021).
REQ-029 flush SHALL empty the queue at the next edge, suppress pop, sb_clr and flag update that cycle; flags_q retained.
REQ-030 rf_we SHALL be 0 while flush is high.

Reset
REQ-031 rst_n low SHALL asynchronously clear pointers, count=0, flags_q=0, sb_clr=0, sb_idx=0; rf_we=0, in_ready=1 thereafter.
REQ-032 Reset mid-write SHALL drop all queued entries with no sb_clr for them.

Configuration
REQ-033 Macro GPU_WB_FLAGS_EN defined: flags_q behaves per REQ-026/029.
REQ-034 Macro GPU_WB_FLAGS_EN undefined: no flag storage; flags_q tied to 0; in_flags ignored.

Structure
REQ-035 Package gpu_pkg SHALL hold opcode constants OPC_ADD=0 through OPC_ROR=13, flag bit indices FLAG_Z=3,S=2,O=1,C=0, and typedef wb_entry_t {opc, rd, result, flags}.
REQ-036 Storage SHALL be a sub-module gpu_wb_fifo (parameterised DEPTH, entry type); control and flags live in gpu_alu_wb.

Verification
REQ-037 Push rd=3,result=0x0000_0005 with rf_ready=1 -> rf_we next cycle with addr 3, data 5; sb_clr=1, sb_idx=3 one cycle later; count returns 0.
REQ-038 rf_ready=0, push 5 results -> in_ready drops after 4th (DEPTH=4), count=4, 5th not accepted; release rf_ready -> 4 writes in order.
REQ-039 Push rd=0 -> no rf_we, sb_clr with sb_idx=0, count 0 after one cycle.
REQ-040 Push opc=0 flags=4'b0011 then opc=4 flags=4'b1000 -> flags_q 0011 then 1011 (o,c held).
REQ-041 Queue 3 entries, assert flush with in_valid=1 -> count=0 next cycle, no rf_we, no sb_clr, input dropped.
REQ-042 Assert rst_n=0 asynchronously with 2 entries queued -> outputs zero immediately; no writes after release.
